motor_off_timer: RTL and testbench



---
 rtl/motor_off_timer_pkg.sv | 19 +
 rtl/motor_off_timer_if.sv | 28 ++
 rtl/motor_off_timer_tick_prescaler.sv | 43 ++++
 rtl/motor_off_timer.sv | 126 ++++++++++++
 tb/tb_motor_off_timer.sv | 137 +++++++++++++
 5 files changed

// File: rtl/motor_off_timer_pkg.sv
// Shared definitions for the fan-motor auto-off timer and its neighbours
// (seven-segment display, PWM state FSM).
//   state_e       : countdown FSM state encoding
//   DEF_TICK_DIV  : default clock cycles per one-second tick
//   DEF_UNIT_SEC  : default seconds per unit of the time-select value
//   DEF_REM_W     : default remaining-seconds counter width (holds 31*60)
package motor_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COUNT   = 2'd1,
    ST_EXPIRED = 2'd2
  } state_e;

  localparam int unsigned DEF_TICK_DIV = 100_000_000;
  localparam int unsigned DEF_UNIT_SEC = 60;
  localparam int unsigned DEF_REM_W    = 11;

endpackage

// File: rtl/motor_off_timer_if.sv
// Control/status bundle between the auto-off timer and its environment.
//   i_timeSet  : selected duration in units (0 = no timer)
//   i_run      : motor running
//   o_remain   : remaining seconds
//   o_active   : countdown in progress
//   o_expire   : single-cycle expiry pulse
//   o_forceOff : level request to the PWM FSM to turn the motor off
// master = environment (time-select / PWM FSM / display), slave = timer.
interface motor_off_timer_if #(
  parameter int REM_W = 11
);
  logic [4:0]       i_timeSet;
  logic             i_run;
  logic [REM_W-1:0] o_remain;
  logic             o_active;
  logic             o_expire;
  logic             o_forceOff;

  modport master (
    output i_timeSet, i_run,
    input  o_remain, o_active, o_expire, o_forceOff
  );

  modport slave (
    input  i_timeSet, i_run,
    output o_remain, o_active, o_expire, o_forceOff
  );
endinterface

// File: rtl/motor_off_timer_tick_prescaler.sv
// One-second tick generator for the auto-off timer.
//   i_clk     : system clock
//   i_reset_n : synchronous active-low reset
//   i_clear   : forces the count back to 0 (wins over counting)
//   o_tick    : high on the cycle the count equals TICK_DIV-1
module tick_prescaler
  import motor_timer_pkg::*;
#(
  parameter int unsigned TICK_DIV = DEF_TICK_DIV
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_clear,
  output logic o_tick
);

  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_clear) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_tick = (cnt_q == CNT_LAST);

endmodule

// File: rtl/motor_off_timer.sv
// Auto-off countdown controller for the fan motor. Loads the selected
// duration while the motor runs, counts it down in one-second ticks and
// then holds a force-off request until the motor is seen stopped.
//   i_clk     : system clock, all logic on its rising edge
//   i_reset_n : synchronous active-low reset
//   bus       : motor_off_timer_if slave (time select, run, status outputs)
//
// state      | meaning
// -----------+-----------------------------------------------
// ST_IDLE    | no countdown, remain = 0, prescaler held clear
// ST_COUNT   | counting down remaining seconds
// ST_EXPIRED | countdown finished, forcing the motor off
module motor_off_timer
  import motor_timer_pkg::*;
#(
  parameter int unsigned TICK_DIV = DEF_TICK_DIV,
  parameter int unsigned UNIT_SEC = DEF_UNIT_SEC,
  parameter int unsigned REM_W    = DEF_REM_W
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  motor_off_timer_if.slave   bus
);

  localparam logic [REM_W-1:0] UNIT_W = REM_W'(UNIT_SEC);

  state_e           state_q, state_d;
  logic [REM_W-1:0] remain_q, remain_d;
  logic [4:0]       set_q, set_d;
  logic             expire_q, expire_d;
  logic             presc_clear;
  logic             tick;
  logic [REM_W-1:0] load_val;
  logic             ts_changed;

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_presc (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_clear   (presc_clear),
    .o_tick    (tick)
  );

  assign load_val   = REM_W'(bus.i_timeSet) * UNIT_W;
  assign ts_changed = (bus.i_timeSet != set_q);

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q  <= ST_IDLE;
      remain_q <= '0;
      set_q    <= '0;
      expire_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      remain_q <= remain_d;
      set_q    <= set_d;
      expire_q <= expire_d;
    end
  end

  // Priority inside COUNT: run drop, then time-select change, then tick.
  // A run drop or reload on the final tick therefore suppresses expiry.
  always_comb begin
    state_d     = state_q;
    remain_d    = remain_q;
    set_d       = set_q;
    expire_d    = 1'b0;
    presc_clear = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        presc_clear = 1'b1;
        remain_d    = '0;
        if (bus.i_run && (bus.i_timeSet != 5'd0)) begin
          state_d  = ST_COUNT;
          remain_d = load_val;
          set_d    = bus.i_timeSet;
        end
      end
      ST_COUNT: begin
        if (!bus.i_run) begin
          state_d     = ST_IDLE;
          remain_d    = '0;
          presc_clear = 1'b1;
        end else if (ts_changed) begin
          set_d       = bus.i_timeSet;
          presc_clear = 1'b1;
          if (bus.i_timeSet == 5'd0) begin
            state_d  = ST_IDLE;
            remain_d = '0;
          end else begin
            remain_d = load_val;
          end
        end else if (tick) begin
          if (remain_q == REM_W'(1)) begin
            state_d  = ST_EXPIRED;
            remain_d = '0;
            expire_d = 1'b1;
          end else if (remain_q != '0) begin
            remain_d = remain_q - REM_W'(1);
          end
        end
      end
      ST_EXPIRED: begin
        presc_clear = 1'b1;
        remain_d    = '0;
        if (!bus.i_run) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        remain_d    = '0;
        presc_clear = 1'b1;
      end
    endcase
  end

  always_comb begin
    bus.o_remain   = remain_q;
    bus.o_active   = (state_q == ST_COUNT);
    bus.o_forceOff = (state_q == ST_EXPIRED);
    bus.o_expire   = expire_q;
  end

endmodule

// File: tb/tb_motor_off_timer.sv
// Scoreboard bench for motor_off_timer with TICK_DIV=4, UNIT_SEC=1.
// Stimulus drives inputs on the falling edge and queues the outputs expected
// after the next rising edge; a monitor pops and compares after each edge.
module tb_motor_off_timer;

  localparam int REM_W = 11;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  motor_off_timer_if #(.REM_W(REM_W)) bus ();

  motor_off_timer #(
    .TICK_DIV (4),
    .UNIT_SEC (1),
    .REM_W    (REM_W)
  ) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int    remain;
    bit    active;
    bit    expire;
    bit    force_off;
    string tag;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;

  task automatic cmp(input string tag, input string fld, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s.%s got=%0d exp=%0d", tag, fld, got, want);
    end
  endtask

  task automatic cyc(input bit run, input int ts, input bit rn,
                     input int rem, input bit act, input bit ex, input bit fo,
                     input string tag);
    exp_t e;
    @(negedge clk);
    rst_n         = rn;
    bus.i_run     = run;
    bus.i_timeSet = 5'(ts);
    e.remain    = rem;
    e.active    = act;
    e.expire    = ex;
    e.force_off = fo;
    e.tag       = tag;
    exp_q.push_back(e);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        cmp(e.tag, "remain",   int'(bus.o_remain),   e.remain);
        cmp(e.tag, "active",   int'(bus.o_active),   int'(e.active));
        cmp(e.tag, "expire",   int'(bus.o_expire),   int'(e.expire));
        cmp(e.tag, "forceOff", int'(bus.o_forceOff), int'(e.force_off));
      end
    end
  end

  initial begin
    bus.i_run     = 1'b0;
    bus.i_timeSet = 5'd0;
    rst_n         = 1'b0;

    // reset held with a valid start request, then load on release
    repeat (3) cyc(1, 10, 0, 0, 0, 0, 0, "rst_hold");
    cyc(1, 10, 1, 10, 1, 0, 0, "load10");

    // full countdown of 10 seconds, expiry 40 cycles after load
    for (int j = 1; j <= 39; j++) cyc(1, 10, 1, 10 - j / 4, 1, 0, 0, "cnt10");
    cyc(1, 10, 1, 0, 0, 1, 1, "expire");
    cyc(1, 10, 1, 0, 0, 0, 1, "expire_pulse");
    cyc(1, 20, 1, 0, 0, 0, 1, "exp_ts20");
    cyc(1,  0, 1, 0, 0, 0, 1, "exp_ts0");
    cyc(1, 10, 1, 0, 0, 0, 1, "exp_ts10");
    cyc(0, 10, 1, 0, 0, 0, 0, "run_drop");

    // reload mid-count restarts the prescaler, then select 0 stops
    cyc(1, 20, 1, 20, 1, 0, 0, "load20");
    for (int j = 1; j <= 28; j++) cyc(1, 20, 1, 20 - j / 4, 1, 0, 0, "cnt20");
    cyc(1, 10, 1, 10, 1, 0, 0, "reload10");
    for (int k = 1; k <= 4; k++) cyc(1, 10, 1, 10 - k / 4, 1, 0, 0, "post_reload");
    cyc(1, 0, 1, 0, 0, 0, 0, "ts_zero");

    // no timer selected while running
    for (int j = 0; j < 50; j++) cyc(1, 0, 1, 0, 0, 0, 0, "ts0_run");

    // run drop coincident with the final tick
    cyc(1, 3, 1, 3, 1, 0, 0, "load3");
    for (int j = 1; j <= 11; j++) cyc(1, 3, 1, 3 - j / 4, 1, 0, 0, "cnt3");
    cyc(0, 3, 1, 0, 0, 0, 0, "drop_final");
    cyc(0, 3, 1, 0, 0, 0, 0, "no_expire");

    // time-select change coincident with the final tick
    cyc(1, 2, 1, 2, 1, 0, 0, "load2");
    for (int j = 1; j <= 7; j++) cyc(1, 2, 1, 2 - j / 4, 1, 0, 0, "cnt2");
    cyc(1, 1, 1, 1, 1, 0, 0, "reload_final");
    for (int k = 1; k <= 3; k++) cyc(1, 1, 1, 1, 1, 0, 0, "cnt1");
    cyc(1, 1, 1, 0, 0, 1, 1, "expire1");
    cyc(0, 1, 1, 0, 0, 0, 0, "exp_off");

    // one-cycle reset mid-count, then restart with run still held
    cyc(1, 10, 1, 10, 1, 0, 0, "load10b");
    for (int j = 1; j <= 12; j++) cyc(1, 10, 1, 10 - j / 4, 1, 0, 0, "cnt10b");
    cyc(1, 10, 0, 0, 0, 0, 0, "mid_reset");
    cyc(1, 10, 1, 10, 1, 0, 0, "restart");
    for (int j = 1; j <= 4; j++) cyc(1, 10, 1, 10 - j / 4, 1, 0, 0, "restart_cnt");
    cyc(0, 0, 1, 0, 0, 0, 0, "final_idle");

    for (int w = 0; w < 5; w++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
      #2;
    end
    cmp("drain", "pending", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
